// File: rtl/i2c_controller_if.sv
// i2c_controller_if: command/response channel between a local command source and the I2C controller.
interface i2c_controller_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic                  cmd_rw;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  done;
   logic                  ack_error;
   logic                  busy;
   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      input  cmd_ready, rd_data, done, ack_error, busy
   );
   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
      output cmd_ready, rd_data, done, ack_error, busy
   );
endinterface

// File: rtl/i2c_controller.sv
// i2c_controller: single-master, single-byte I2C initiator on open-drain sda/scl.
// Accept-to-done latency is exactly 77*QTR_CYCLES cycles (41*QTR_CYCLES on address NACK).
module i2c_controller #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8,
   parameter int QTR_CYCLES = 250
) (
   input  logic            clk_i,
   input  logic            rst_i,
   inout  wire             sda_io,
   inout  wire             scl_io,
   i2c_controller_if.slave bus
);
   localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
   localparam int BW = $clog2(SW);
   localparam int CW = $clog2(QTR_CYCLES);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            ph_q, ph_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [SW-1:0]         shift_q, shift_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rd_q, rd_d;
   logic                  rw_q, rw_d, err_q, err_d, nack_q, nack_d, done_q, done_d;
   logic                  sda_low_q, sda_low_d, scl_low_q, scl_low_d;
   logic                  sda_in, accept, tick, tx_state, shift_state;

   assign sda_io = sda_low_q ? 1'b0 : 1'bz;
   assign scl_io = scl_low_q ? 1'b0 : 1'bz;
   assign sda_in = sda_io;

   assign bus.cmd_ready = (state_q == IDLE) && !done_q;
   assign bus.busy      = state_q != IDLE;
   assign bus.done      = done_q;
   assign bus.rd_data   = rd_q;
   assign bus.ack_error = err_q;

   assign accept      = bus.cmd_valid && bus.cmd_ready;
   assign tick        = cnt_q == CW'(QTR_CYCLES - 1);
   assign tx_state    = state_q == ADDR || state_q == WRITE;
   assign shift_state = tx_state || state_q == READ;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ph_q      <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         rw_q      <= 1'b0;
         err_q     <= 1'b0;
         nack_q    <= 1'b0;
         done_q    <= 1'b0;
         sda_low_q <= 1'b0;
         scl_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         rw_q      <= rw_d;
         err_q     <= err_d;
         nack_q    <= nack_d;
         done_q    <= done_d;
         sda_low_q <= sda_low_d;
         scl_low_q <= scl_low_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
      ph_d      = ph_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      rw_d      = rw_q;
      err_d     = err_q;
      nack_d    = nack_q;
      done_d    = 1'b0;
      sda_low_d = sda_low_q;
      scl_low_d = scl_low_q;
      if (accept) begin
         state_d = START;
         ph_d    = '0;
         rw_d    = bus.cmd_rw;
         wdata_d = bus.cmd_wdata;
         err_d   = 1'b0;
         shift_d = SW'({bus.cmd_addr, bus.cmd_rw}) << (SW - ADDR_WIDTH - 1);
      end else if (tick && state_q != IDLE) begin
         ph_d = ph_q + 2'd1;
         case (state_q)
            START: begin
               sda_low_d = 1'b1;
               if (ph_q == 2'd1) begin
                  scl_low_d = 1'b1;
                  state_d   = ADDR;
                  ph_d      = '0;
                  bit_d     = BW'(ADDR_WIDTH);
               end
            end
            STOP: begin
               sda_low_d = ph_q != 2'd2;
               scl_low_d = ph_q == 2'd0;
               if (ph_q == 2'd2) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  ph_d    = '0;
               end
            end
            default: begin
               case (ph_q)
                  2'd0: sda_low_d = tx_state && !shift_q[SW-1];
                  2'd1: scl_low_d = 1'b0;
                  2'd2: begin
                     // Transmit and receive share one register: the sample refills the freed LSB.
                     nack_d  = sda_in;
                     shift_d = shift_state ? {shift_q[SW-2:0], sda_in} : shift_q;
                  end
                  default: begin
                     scl_low_d = 1'b1;
                     bit_d     = bit_q - 1'b1;
                     case (state_q)
                        ADDR:  state_d = (bit_q == '0) ? ADDR_ACK : ADDR;
                        WRITE: state_d = (bit_q == '0) ? WRITE_ACK : WRITE;
                        READ:  state_d = (bit_q == '0) ? READ_NACK : READ;
                        ADDR_ACK: begin
                           err_d   = nack_q;
                           state_d = nack_q ? STOP : rw_q ? READ : WRITE;
                           bit_d   = BW'(DATA_WIDTH - 1);
                           shift_d = SW'(wdata_q) << (SW - DATA_WIDTH);
                        end
                        WRITE_ACK: begin
                           err_d   = nack_q;
                           state_d = STOP;
                        end
                        default: begin
                           rd_d    = shift_q[DATA_WIDTH-1:0];
                           state_d = STOP;
                        end
                     endcase
                  end
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed bench with a behavioural I2C target at 0x2A and a done-time scoreboard.
module tb_i2c_controller;
   localparam int QTR = 4;

   typedef struct {
      logic [7:0] abyte;
      logic [7:0] wbyte;
      logic [7:0] rd;
      logic       err;
      logic       full;
      int         lat;
      int         rises;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tgt_low = 1'b0;
   wire  sda, scl;
   int   checks = 0, errors = 0, cyc = 0, acc = 0, rises = 0, rises_acc = 0;
   logic [7:0] seen_addr = 8'h00, seen_w = 8'h00;
   logic       seen_mnack = 1'b0;
   exp_t sb[$];

   pullup (sda);
   pullup (scl);
   assign sda = tgt_low ? 1'b0 : 1'bz;

   i2c_controller_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

   i2c_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .QTR_CYCLES(QTR)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sda_io(sda),
      .scl_io(scl),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
         acc       = cyc;
         rises_acc = rises;
      end
   end

   initial forever begin
      @(posedge scl);
      rises++;
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
               e = sb.pop_front();
               chk("latency", cyc - acc, e.lat);
               chk("ack_error", bus.ack_error, e.err);
               chk("addr_byte", seen_addr, e.abyte);
               chk("scl_pulses", rises - rises_acc, e.rises);
               chk("busy_at_done", bus.busy, 0);
               if (e.full && !e.abyte[0]) chk("write_byte", seen_w, e.wbyte);
               if (e.full && e.abyte[0]) begin
                  chk("rd_data", bus.rd_data, e.rd);
                  chk("master_nack", seen_mnack, 1);
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic target(input logic nack_wr, input logic [7:0] rdata);
      logic [7:0] a = 8'h00, w = 8'h00;
      @(negedge sda iff scl === 1'b1);
      seen_addr  = 8'h00;
      seen_w     = 8'h00;
      seen_mnack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge scl);
         a = {a[6:0], sda};
      end
      seen_addr = a;
      if (a[7:1] != 7'h2A) return;
      @(negedge scl);
      tgt_low = 1'b1;
      @(negedge scl);
      if (!a[0]) begin
         tgt_low = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(posedge scl);
            w = {w[6:0], sda};
         end
         seen_w = w;
         @(negedge scl);
         tgt_low = !nack_wr;
         @(negedge scl);
         tgt_low = 1'b0;
      end else begin
         for (int i = 7; i >= 0; i--) begin
            tgt_low = !rdata[i];
            @(negedge scl);
         end
         tgt_low = 1'b0;
         @(posedge scl);
         seen_mnack = sda;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.done !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", bus.done, 1);
   endtask

   task automatic push(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                       input logic [7:0] rdata, input logic err, input logic full,
                       input int lat, input int nrises);
      exp_t e;
      e.abyte = {addr, rw};
      e.wbyte = wdata;
      e.rd    = rdata;
      e.err   = err;
      e.full  = full;
      e.lat   = lat;
      e.rises = nrises;
      sb.push_back(e);
   endtask

   task automatic run(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                      input logic nack_wr, input logic [7:0] rdata, input logic err,
                      input logic full, input int lat, input int nrises);
      push(addr, rw, wdata, rdata, err, full, lat, nrises);
      fork
         target(nack_wr, rdata);
         begin
            @(negedge clk);
            bus.cmd_addr  = addr;
            bus.cmd_rw    = rw;
            bus.cmd_wdata = wdata;
            bus.cmd_valid = 1'b1;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk("ack_err_clear", bus.ack_error, 0);
            chk("ready_low", bus.cmd_ready, 0);
            wait_done();
         end
      join
      @(negedge clk);
      chk("ready_back", bus.cmd_ready, 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_rw    = 1'b0;
      bus.cmd_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ack_error", bus.ack_error, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_sda", sda, 1);
      chk("rst_scl", scl, 1);

      run(7'h2A, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b1, 77 * QTR, 19);
      run(7'h2A, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1, 77 * QTR, 19);
      run(7'h11, 1'b0, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 41 * QTR, 10);
      run(7'h2A, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 77 * QTR, 19);
      chk("ack_err_hold", bus.ack_error, 1);
      chk("rd_hold", bus.rd_data, 8'h5A);
      run(7'h2A, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 77 * QTR, 19);

      push(7'h2A, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, 77 * QTR, 19);
      push(7'h11, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 41 * QTR, 10);
      fork
         begin
            target(1'b0, 8'h00);
            target(1'b0, 8'h00);
         end
         begin
            @(negedge clk);
            bus.cmd_addr  = 7'h2A;
            bus.cmd_rw    = 1'b0;
            bus.cmd_wdata = 8'h3C;
            bus.cmd_valid = 1'b1;
            @(negedge clk);
            bus.cmd_addr  = 7'h11;
            bus.cmd_wdata = 8'h77;
            repeat (40) @(negedge clk);
            chk("held_ready_low", bus.cmd_ready, 0);
            chk("held_busy", bus.busy, 1);
            wait_done();
            @(negedge clk);
            chk("held_ready_back", bus.cmd_ready, 1);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            wait_done();
         end
      join
      @(negedge clk);

      bus.cmd_addr  = 7'h2A;
      bus.cmd_rw    = 1'b0;
      bus.cmd_wdata = 8'h00;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (74) @(negedge clk);
      chk("mid_busy", bus.busy, 1);
      chk("mid_scl_low", scl, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_sda", sda, 1);
      chk("mid_rst_scl", scl, 1);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ready", bus.cmd_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      run(7'h2A, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 77 * QTR, 19);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
